// File: rtl/run_sequencer.sv
// Job sequencer in front of the processor core: preloads operand bytes into data
// memory, launches the program via Start/Ack, bounds the run, then drains results.
module run_sequencer #(
    parameter logic [7:0]  LOAD_BASE = 8'd128,
    parameter int          LOAD_LEN  = 8,
    parameter logic [7:0]  RES_BASE  = 8'd5,
    parameter int          RES_LEN   = 4,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Go,
    input  logic        InValid,
    input  logic [7:0]  InData,
    output logic        InReady,
    output logic        MemSel,
    output logic        MemWrEn,
    output logic [7:0]  MemAddr,
    output logic [7:0]  MemWrData,
    input  logic [7:0]  MemRdData,
    output logic        Start,
    input  logic        Ack,
    output logic        OutValid,
    output logic [7:0]  OutData,
    input  logic        OutReady,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [15:0] RunCycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LAUNCH, S_RUN, S_DRAIN, S_DONE
    } state_t;

    localparam logic [7:0] LOAD_LAST  = 8'(LOAD_LEN - 1);
    localparam logic [7:0] RES_LAST   = 8'(RES_LEN - 1);
    localparam bit         LOAD_EMPTY = (LOAD_LEN == 0);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        error_q, error_d;
    logic [15:0] run_cycles_q, run_cycles_d;
    logic        start_q, mem_sel_q, busy_q, done_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        error_d      = error_q;
        run_cycles_d = run_cycles_q;
        InReady      = 1'b0;
        MemWrEn      = 1'b0;
        MemAddr      = LOAD_BASE + idx_q;
        MemWrData    = 8'h00;
        OutValid     = 1'b0;
        OutData      = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    idx_d   = 8'h00;
                    cnt_d   = 16'h0000;
                    error_d = 1'b0;
                    state_d = LOAD_EMPTY ? S_LAUNCH : S_LOAD;
                end
            end
            S_LOAD: begin
                InReady   = 1'b1;
                MemWrData = InData;
                // Suppress the write on a reset edge so an aborted load leaves DM untouched.
                MemWrEn   = InValid & ~Reset;
                if (InValid) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == LOAD_LAST) state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                idx_d   = 8'h00;
                cnt_d   = 16'h0000;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q != TIMEOUT) cnt_d = cnt_q + 16'd1;
                // cnt_q==0 marks the first RUN cycle, where a stale Ack may still be high.
                if (Ack && cnt_q != 16'h0000) begin
                    run_cycles_d = cnt_q;
                    state_d      = S_DRAIN;
                end else if (cnt_q == TIMEOUT) begin
                    run_cycles_d = cnt_q;
                    error_d      = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DRAIN: begin
                MemAddr  = RES_BASE + idx_q;
                OutValid = 1'b1;
                OutData  = MemRdData;
                if (OutReady) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == RES_LAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                idx_d   = 8'h00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 8'h00;
            cnt_q        <= 16'h0000;
            error_q      <= 1'b0;
            run_cycles_q <= 16'h0000;
            start_q      <= 1'b1;
            mem_sel_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            error_q      <= error_d;
            run_cycles_q <= run_cycles_d;
            start_q      <= (state_d != S_RUN);
            mem_sel_q    <= !(state_d == S_LAUNCH || state_d == S_RUN);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
        end
    end

    assign Start     = start_q;
    assign MemSel    = mem_sel_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = error_q;
    assign RunCycles = run_cycles_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: one main instance plus two instances for the
// address-wrap and zero-length-load configurations.
module tb_run_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance A: defaults, short timeout
    logic go_a = 0, iv_a = 0, ack_a = 0, or_a = 0;
    logic [7:0] id_a = 0;
    logic ir_a, ms_a, we_a, st_a, ov_a, bz_a, dn_a, er_a;
    logic [7:0] ma_a, wd_a, rd_a, od_a;
    logic [15:0] rc_a;
    logic [7:0] dma [256];
    int wr_a = 0, done_a = 0, ovcnt_a = 0;

    // instance B: load window wraps past 255
    logic go_b = 0, iv_b = 0;
    logic [7:0] id_b = 0;
    logic ir_b, ms_b, we_b, st_b, ov_b, bz_b, dn_b, er_b;
    logic [7:0] ma_b, wd_b, rd_b, od_b;
    logic [15:0] rc_b;
    logic [7:0] dmb [256];

    // instance C: empty load
    logic go_c = 0;
    logic ir_c, ms_c, we_c, st_c, ov_c, bz_c, dn_c, er_c;
    logic [7:0] ma_c, wd_c, od_c;
    logic [15:0] rc_c;

    run_sequencer #(.TIMEOUT(16'd20)) dut_a (
        .Clk(clk), .Reset(rst), .Go(go_a), .InValid(iv_a), .InData(id_a), .InReady(ir_a),
        .MemSel(ms_a), .MemWrEn(we_a), .MemAddr(ma_a), .MemWrData(wd_a), .MemRdData(rd_a),
        .Start(st_a), .Ack(ack_a), .OutValid(ov_a), .OutData(od_a), .OutReady(or_a),
        .Busy(bz_a), .Done(dn_a), .Error(er_a), .RunCycles(rc_a));

    run_sequencer #(.LOAD_BASE(8'd252), .TIMEOUT(16'd20)) dut_b (
        .Clk(clk), .Reset(rst), .Go(go_b), .InValid(iv_b), .InData(id_b), .InReady(ir_b),
        .MemSel(ms_b), .MemWrEn(we_b), .MemAddr(ma_b), .MemWrData(wd_b), .MemRdData(rd_b),
        .Start(st_b), .Ack(1'b0), .OutValid(ov_b), .OutData(od_b), .OutReady(1'b1),
        .Busy(bz_b), .Done(dn_b), .Error(er_b), .RunCycles(rc_b));

    run_sequencer #(.LOAD_LEN(0), .TIMEOUT(16'd20)) dut_c (
        .Clk(clk), .Reset(rst), .Go(go_c), .InValid(1'b0), .InData(8'h00), .InReady(ir_c),
        .MemSel(ms_c), .MemWrEn(we_c), .MemAddr(ma_c), .MemWrData(wd_c), .MemRdData(8'h00),
        .Start(st_c), .Ack(1'b0), .OutValid(ov_c), .OutData(od_c), .OutReady(1'b1),
        .Busy(bz_c), .Done(dn_c), .Error(er_c), .RunCycles(rc_c));

    assign rd_a = dma[ma_a];
    assign rd_b = dmb[ma_b];

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) dma[i] <= 8'h55;
            dma[5] <= 8'hDE; dma[6] <= 8'hAD; dma[7] <= 8'hBE; dma[8] <= 8'hEF;
        end else if (we_a) begin
            dma[ma_a] <= wd_a;
        end
    end

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) dmb[i] <= 8'h55;
        end else if (we_b) begin
            dmb[ma_b] <= wd_b;
        end
    end

    always @(posedge clk) begin
        if (we_a) wr_a <= wr_a + 1;
        if (dn_a) done_a <= done_a + 1;
        if (ov_a) ovcnt_a <= ovcnt_a + 1;
    end

    logic [7:0] got [8];
    int gotn;

    // Drives A's load phase from the first LOAD cycle; returns at the LAUNCH cycle.
    task automatic load_a(input bit toggle, input logic [7:0] base, output int cyc, output int nwr);
        int k; int w0; bit ph;
        k = 0; cyc = 0; w0 = wr_a; ph = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!ir_a) break;
            cyc++;
            iv_a = toggle ? ph : 1'b1;
            id_a = base + 8'(k);
            if (iv_a) k++;
            ph = ~ph;
            @(negedge clk);
        end
        iv_a = 1'b0;
        nwr = wr_a - w0;
    endtask

    // Core model: Ack raised 'dly' cycles after Start is seen low; returns one cycle after Ack.
    task automatic run_a(input int dly, input bit go_noise);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!st_a) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL start_fall: Start=%b required 0", st_a); end
        go_a = go_noise;
        repeat (dly) @(negedge clk);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        go_a = 1'b0;
    endtask

    task automatic drain_a(input int stall_byte, input int stall_n, input bit go_noise, output int cyc);
        int b; int st;
        b = 0; st = 0; cyc = 0;
        for (int i = 0; i < 64; i++) begin
            if (!ov_a) break;
            cyc++;
            if (b == stall_byte && st < stall_n) begin
                or_a = 1'b0;
                go_a = go_noise;
                st++;
                checks++;
                if (od_a !== 8'hAD) begin errors++; $display("FAIL hold_data: OutData=%h required AD", od_a); end
            end else begin
                or_a = 1'b1;
                if (b < 8) got[b] = od_a;
                b++;
            end
            @(negedge clk);
        end
        or_a = 1'b0;
        go_a = 1'b0;
        gotn = b;
    endtask

    task automatic check_stream();
        logic [7:0] exp [4];
        exp[0] = 8'hDE; exp[1] = 8'hAD; exp[2] = 8'hBE; exp[3] = 8'hEF;
        checks++;
        if (gotn !== 4) begin errors++; $display("FAIL out_count: got %0d required 4", gotn); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL out_byte%0d: got %h required %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reset();
        checks++; if (st_a !== 1'b1) begin errors++; $display("FAIL rst_start: %b required 1", st_a); end
        checks++; if (ms_a !== 1'b1) begin errors++; $display("FAIL rst_memsel: %b required 1", ms_a); end
        checks++; if (ir_a !== 1'b0) begin errors++; $display("FAIL rst_inready: %b required 0", ir_a); end
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL rst_wren: %b required 0", we_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL rst_outvalid: %b required 0", ov_a); end
        checks++; if (bz_a !== 1'b0) begin errors++; $display("FAIL rst_busy: %b required 0", bz_a); end
        checks++; if (dn_a !== 1'b0) begin errors++; $display("FAIL rst_done: %b required 0", dn_a); end
        checks++; if (er_a !== 1'b0) begin errors++; $display("FAIL rst_error: %b required 0", er_a); end
        checks++; if (rc_a !== 16'd0) begin errors++; $display("FAIL rst_runcycles: %0d required 0", rc_a); end
        checks++; if (ma_a !== 8'd128) begin errors++; $display("FAIL rst_addr: %0d required 128", ma_a); end
        checks++; if (wd_a !== 8'd0) begin errors++; $display("FAIL rst_wrdata: %h required 00", wd_a); end
        checks++; if (ma_b !== 8'd252) begin errors++; $display("FAIL rst_addr_b: %0d required 252", ma_b); end
    endtask

    task automatic test_reset_mid_load();
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        checks++; if (bz_a !== 1'b1) begin errors++; $display("FAIL go_busy: %b required 1", bz_a); end
        for (int i = 0; i < 3; i++) begin
            iv_a = 1'b1; id_a = 8'(i);
            @(negedge clk);
        end
        rst = 1'b1; id_a = 8'h03;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (st_a !== 1'b1) begin errors++; $display("FAIL midrst_start: %b required 1", st_a); end
        checks++; if (bz_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: %b required 0", bz_a); end
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL midrst_wren: %b required 0", we_a); end
        checks++; if (ir_a !== 1'b0) begin errors++; $display("FAIL midrst_inready: %b required 0", ir_a); end
        iv_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (dma[128+i] !== 8'(i)) begin errors++; $display("FAIL midrst_dm%0d: %h required %h", 128+i, dma[128+i], 8'(i)); end
        end
        for (int i = 131; i < 136; i++) begin
            checks++; if (dma[i] !== 8'h55) begin errors++; $display("FAIL midrst_untouched%0d: %h required 55", i, dma[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_full_job();
        int cyc; int nwr; int d0;
        d0 = done_a;
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        load_a(1'b0, 8'h00, cyc, nwr);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL load_cycles: %0d required 8", cyc); end
        checks++; if (nwr !== 8) begin errors++; $display("FAIL load_writes: %0d required 8", nwr); end
        checks++; if (ms_a !== 1'b0 || st_a !== 1'b1) begin errors++; $display("FAIL launch: MemSel=%b Start=%b required 0,1", ms_a, st_a); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (dma[128+i] !== 8'(i)) begin errors++; $display("FAIL load_dm%0d: %h required %h", 128+i, dma[128+i], 8'(i)); end
        end
        run_a(5, 1'b1);
        checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL ack_outvalid: %b required 1", ov_a); end
        checks++; if (rc_a !== 16'd5) begin errors++; $display("FAIL runcycles: %0d required 5", rc_a); end
        checks++; if (ma_a !== 8'd5) begin errors++; $display("FAIL drain_addr: %0d required 5", ma_a); end
        drain_a(99, 0, 1'b0, cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL drain_cycles: %0d required 4", cyc); end
        checks++; if (dn_a !== 1'b1) begin errors++; $display("FAIL done_pulse: %b required 1", dn_a); end
        check_stream();
        @(negedge clk);
        checks++; if (bz_a !== 1'b0 || dn_a !== 1'b0) begin errors++; $display("FAIL back_idle: Busy=%b Done=%b required 0,0", bz_a, dn_a); end
        checks++; if (er_a !== 1'b0) begin errors++; $display("FAIL job_error: %b required 0", er_a); end
        checks++; if (done_a - d0 !== 1) begin errors++; $display("FAIL done_count: %0d required 1", done_a - d0); end
    endtask

    task automatic test_backpressure();
        int cyc; int nwr; int d0;
        d0 = done_a;
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        load_a(1'b1, 8'h10, cyc, nwr);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL bp_load_cycles: %0d required 16", cyc); end
        checks++; if (nwr !== 8) begin errors++; $display("FAIL bp_writes: %0d required 8", nwr); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (dma[128+i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL bp_dm%0d: %h required %h", 128+i, dma[128+i], 8'h10 + 8'(i)); end
        end
        run_a(5, 1'b0);
        drain_a(1, 3, 1'b1, cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL bp_drain_cycles: %0d required 7", cyc); end
        check_stream();
        @(negedge clk);
        checks++; if (done_a - d0 !== 1) begin errors++; $display("FAIL bp_done_count: %0d required 1", done_a - d0); end
        checks++; if (bz_a !== 1'b0) begin errors++; $display("FAIL bp_idle: Busy=%b required 0", bz_a); end
    endtask

    task automatic test_timeout();
        int cyc; int nwr; int ov0; int d0; bit seen;
        d0 = done_a;
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        load_a(1'b0, 8'h20, cyc, nwr);
        @(negedge clk);
        // first RUN cycle: Ack must be ignored here
        ack_a = 1'b1;
        ov0 = ovcnt_a;
        @(negedge clk);
        ack_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (dn_a) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_done: no Done within budget"); end
        checks++; if (er_a !== 1'b1) begin errors++; $display("FAIL to_error: %b required 1", er_a); end
        checks++; if (rc_a !== 16'd20) begin errors++; $display("FAIL to_runcycles: %0d required 20", rc_a); end
        checks++; if (ovcnt_a !== ov0) begin errors++; $display("FAIL to_outvalid: %0d valid cycles required 0", ovcnt_a - ov0); end
        @(negedge clk);
        checks++; if (bz_a !== 1'b0) begin errors++; $display("FAIL to_idle: Busy=%b required 0", bz_a); end
        checks++; if (done_a - d0 !== 1) begin errors++; $display("FAIL to_done_count: %0d required 1", done_a - d0); end
    endtask

    task automatic test_ack_timeout_tie();
        int cyc; int nwr;
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        checks++; if (er_a !== 1'b0) begin errors++; $display("FAIL go_clears_error: %b required 0", er_a); end
        load_a(1'b0, 8'h30, cyc, nwr);
        run_a(20, 1'b0);
        checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL tie_drain: OutValid=%b required 1", ov_a); end
        checks++; if (er_a !== 1'b0) begin errors++; $display("FAIL tie_error: %b required 0", er_a); end
        checks++; if (rc_a !== 16'd20) begin errors++; $display("FAIL tie_runcycles: %0d required 20", rc_a); end
        drain_a(99, 0, 1'b0, cyc);
        check_stream();
        @(negedge clk);
    endtask

    task automatic test_edges();
        int k;
        go_c = 1'b1;
        go_b = 1'b1;
        @(negedge clk);
        go_c = 1'b0;
        go_b = 1'b0;
        checks++; if (ir_c !== 1'b0 || ms_c !== 1'b0 || st_c !== 1'b1 || bz_c !== 1'b1) begin
            errors++; $display("FAIL empty_launch: InReady=%b MemSel=%b Start=%b Busy=%b required 0,0,1,1", ir_c, ms_c, st_c, bz_c);
        end
        checks++; if (ma_b !== 8'd252) begin errors++; $display("FAIL wrap_first_addr: %0d required 252", ma_b); end
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) begin
                checks++; if (st_c !== 1'b0) begin errors++; $display("FAIL empty_run: Start=%b required 0", st_c); end
            end
            if (!ir_b) break;
            iv_b = 1'b1;
            id_b = 8'hA0 + 8'(k);
            k++;
            @(negedge clk);
        end
        iv_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dmb[(252 + i) % 256] !== 8'hA0 + 8'(i)) begin
                errors++; $display("FAIL wrap_dm%0d: %h required %h", (252 + i) % 256, dmb[(252 + i) % 256], 8'hA0 + 8'(i));
            end
        end
        checks++; if (dmb[4] !== 8'h55 || dmb[251] !== 8'h55) begin errors++; $display("FAIL wrap_bounds: %h %h required 55 55", dmb[4], dmb[251]); end
    endtask

    initial begin
        rst = 1'b1;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset_mid_load();
        test_full_job();
        test_backpressure();
        test_timeout();
        test_ack_timeout_tie();
        test_edges();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
